// File: rtl/snes_pkg.sv
// rtl/snes_pkg.sv - shared SNES pad link definitions
//
// Purpose: constants and types shared by the pad emulator and the pad reader.
//   - snes_state_t : emulator frame state (IDLE / LATCHED / SHIFT / DONE)
//   - BTN_*        : bit positions of each button in the 12-bit buttons vector
//   - SNES_BITS    : number of bits in one serial frame
//   - PAD_ID_TAIL  : wire levels of bits 12..15 (standard pad ID, all high)
//   - wire_word()  : converts pressed=1 buttons to the 16 active-low wire levels
// Ports: none (package).

package snes_pkg;

  localparam int SNES_BITS = 16;

  // Bits 12..15 read back high on a standard pad.
  localparam logic [3:0] PAD_ID_TAIL = 4'b1111;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } snes_state_t;

  // Wire levels for one frame; bit 0 is the first bit the host reads.
  function automatic logic [SNES_BITS-1:0] wire_word(input logic [11:0] pressed);
    return {PAD_ID_TAIL, ~pressed};
  endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// rtl/snes_sync_edge.sv - multi-stage synchronizer with edge pulses
//
// Purpose: brings an asynchronous level into the clk domain and flags its
// synchronized transitions.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   d      in   asynchronous input level
//   level  out  synchronized level (STAGES flops after d)
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition

module snes_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Reset to the line's idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/snes_pad_emulator.sv
// rtl/snes_pad_emulator.sv - device-side SNES pad serial link
//
// Purpose: answers a host's latch/clock pair and shifts out 16 button bits.
// Ports:
//   clk            in   system clock, 50 MHz
//   reset          in   synchronous, active-high
//   latch_snes     in   host latch, asynchronous
//   clk_snes       in   host serial clock, idles high, asynchronous
//   buttons[11:0]  in   pressed = 1, index order from snes_pkg BTN_*
//   data_out_snes  out  serial data, active-low (0 = pressed)
//   busy           out  high while LATCHED or SHIFT
//   frame_done     out  one-cycle pulse after the 16th bit is shifted
//   bit_count[4:0] out  bits shifted in the current frame, 0..16

module snes_pad_emulator
  import snes_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   TIMEOUT_CYCLES = 2000,
  parameter logic TAIL_LEVEL     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch_snes,
  input  logic        clk_snes,
  input  logic [11:0] buttons,
  output logic        data_out_snes,
  output logic        busy,
  output logic        frame_done,
  output logic [4:0]  bit_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic lat_s, lat_rise, lat_fall;
  logic clk_s, clk_rise, clk_fall;
  logic unused_edges;

  snes_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lat_sync (
    .clk   (clk),
    .reset (reset),
    .d     (latch_snes),
    .level (lat_s),
    .rise  (lat_rise),
    .fall  (lat_fall)
  );

  snes_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (clk_snes),
    .level (clk_s),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // The FSM acts on the latch level and clock rises only.
  assign unused_edges = lat_rise | lat_fall | clk_s | clk_fall;

  snes_state_t           state;
  logic [SNES_BITS-1:0]  sr;
  logic [TW-1:0]         tcnt;
  logic [SNES_BITS-1:0]  load_word;
  logic [SNES_BITS-1:0]  shifted;

  assign load_word = wire_word(buttons);
  assign shifted   = {1'b1, sr[SNES_BITS-1:1]};

  // data_out_snes is registered, so each branch drives it from the value sr
  // takes in the same edge (load_word[0] on load, sr[1] on shift).
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      sr            <= '1;
      tcnt          <= '0;
      data_out_snes <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      bit_count     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (lat_s) begin
        // Latch wins in every state, including over a simultaneous clock rise.
        state         <= ST_LATCHED;
        sr            <= load_word;
        data_out_snes <= load_word[0];
        busy          <= 1'b1;
        bit_count     <= '0;
        tcnt          <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            data_out_snes <= 1'b1;
            busy          <= 1'b0;
            bit_count     <= '0;
          end
          ST_LATCHED: begin
            // Latch just fell: bit 0 already sits on the wire.
            state <= ST_SHIFT;
            tcnt  <= '0;
            busy  <= 1'b1;
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              tcnt      <= '0;
              sr        <= shifted;
              bit_count <= bit_count + 5'd1;
              if (bit_count == 5'(SNES_BITS - 1)) begin
                state         <= ST_DONE;
                frame_done    <= 1'b1;
                busy          <= 1'b0;
                data_out_snes <= TAIL_LEVEL;
              end else begin
                data_out_snes <= sr[1];
              end
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              // Host went quiet mid-frame: drop it without frame_done.
              state         <= ST_IDLE;
              tcnt          <= '0;
              busy          <= 1'b0;
              bit_count     <= '0;
              data_out_snes <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ST_DONE: begin
            data_out_snes <= TAIL_LEVEL;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_emulator.sv
// tb/tb_snes_pad_emulator.sv - scoreboard bench for snes_pad_emulator

module tb_snes_pad_emulator;

  localparam int   SYNC = 2;
  localparam int   TMO  = 2000;
  localparam logic TAIL = 1'b0;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        latch_snes = 1'b0;
  logic        clk_snes   = 1'b1;
  logic [11:0] buttons    = 12'h000;
  logic        data_out_snes;
  logic        busy;
  logic        frame_done;
  logic [4:0]  bit_count;

  snes_pad_emulator #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO),
    .TAIL_LEVEL     (TAIL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .latch_snes    (latch_snes),
    .clk_snes      (clk_snes),
    .buttons       (buttons),
    .data_out_snes (data_out_snes),
    .busy          (busy),
    .frame_done    (frame_done),
    .bit_count     (bit_count)
  );

  always #10 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc++;

  // Scoreboard queues: expected wire level per host sample, and the cycle of
  // each 16th clock rise that must be answered by one frame_done pulse.
  logic exp_bits[$];
  int   done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Host samples data on every falling clk_snes edge.
  always @(negedge clk_snes) begin
    if (exp_bits.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_sample: got %0b, expected no sample (t=%0t)", data_out_snes, $time);
    end else begin
      logic e;
      e = exp_bits.pop_front();
      check("serial_bit", 32'(data_out_snes), 32'(e));
    end
  end

  // frame_done must appear exactly SYNC+1 cycles after the 16th rise, once.
  always @(negedge clk) begin
    if (!reset && frame_done === 1'b1) begin
      if (done_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame_done: got pulse, expected none (t=%0t)", $time);
      end else begin
        int r;
        r = done_q.pop_front();
        check("frame_done_latency", 32'(cyc - r), 32'(SYNC + 1));
      end
    end
  end

  task automatic hcyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host frame: latch for lat_len cycles (buttons switch from b0 to b1 at
  // switch_at), then nclk low/high clock pulses of half cycles each.
  task automatic run_frame(input logic [11:0] b0, input logic [11:0] b1,
                           input int lat_len, input int switch_at,
                           input int half, input int nclk);
    logic [15:0] w;
    buttons    = b0;
    latch_snes = 1'b1;
    for (int k = 0; k < lat_len; k++) begin
      if (k == switch_at) buttons = b1;
      hcyc(1);
    end
    check("latched_bit_count", 32'(bit_count), 32'd0);
    check("latched_busy", 32'(busy), 32'd1);
    // Reference: wire word reflects the buttons present when latch falls.
    w = {4'hF, ~buttons};
    latch_snes = 1'b0;
    hcyc(half);
    for (int i = 0; i < nclk; i++) begin
      exp_bits.push_back(i < 16 ? w[i] : TAIL);
      clk_snes = 1'b0;
      hcyc(half);
      clk_snes = 1'b1;
      if (i == 15) done_q.push_back(cyc);
      hcyc(half);
    end
    check("frame_bit_count", 32'(bit_count), 32'(nclk > 16 ? 16 : nclk));
    check("frame_busy", 32'(busy), 32'(nclk < 16));
    check("samples_consumed", 32'(exp_bits.size()), 32'd0);
    if (nclk >= 16) begin
      check("tail_level", 32'(data_out_snes), 32'(TAIL));
      check("frame_done_seen", 32'(done_q.size()), 32'd0);
    end
  endtask

  // Clock pulses with no latch: emulator must stay idle, wire high.
  task automatic clocks_only(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(1'b1);
      clk_snes = 1'b0;
      hcyc(half);
      clk_snes = 1'b1;
      hcyc(half);
    end
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    hcyc(4);
    reset = 1'b0;
    check("reset_data", 32'(data_out_snes), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_bit_count", 32'(bit_count), 32'd0);
    hcyc(5);

    // Nominal frame, B pressed.
    run_frame(12'h001, 12'h001, 600, -1, 300, 16);
    // All pressed.
    run_frame(12'hFFF, 12'hFFF, 100, -1, 50, 16);
    // Live tracking during latch.
    run_frame(12'h000, 12'h010, 600, 300, 50, 16);

    // Re-latch mid-frame after 5 clocks, then a full frame with A pressed.
    run_frame(12'($urandom), 12'h000, 100, -1, 50, 5);
    run_frame(12'h100, 12'h100, 100, -1, 50, 16);

    // Timeout after 3 clocks.
    run_frame(12'($urandom), 12'h000, 100, -1, 50, 3);
    hcyc(TMO - 200);
    check("pre_timeout_busy", 32'(busy), 32'd1);
    hcyc(300);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_data", 32'(data_out_snes), 32'd1);
    check("timeout_bit_count", 32'(bit_count), 32'd0);
    clocks_only(3, 30);

    // Reset during SHIFT at bit 7.
    run_frame(12'($urandom), 12'h000, 100, -1, 50, 7);
    reset = 1'b1;
    hcyc(1);
    reset = 1'b0;
    check("rst_mid_data", 32'(data_out_snes), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_bit_count", 32'(bit_count), 32'd0);
    clocks_only(4, 40);
    check("rst_after_clocks_bit_count", 32'(bit_count), 32'd0);
    check("rst_after_clocks_busy", 32'(busy), 32'd0);

    // Randomized frames, some with extra clocks while in DONE.
    repeat (8) begin
      logic [11:0] rb;
      rb = 12'($urandom);
      run_frame(rb, rb, int'($urandom_range(10, 50)), -1,
                int'($urandom_range(8, 40)), 16 + int'($urandom_range(0, 2)));
    end

    hcyc(20);
    check("final_samples_empty", 32'(exp_bits.size()), 32'd0);
    check("final_done_empty", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
